rr_arb8: RTL and testbench
==========================

# rr_arb8

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. It issues a registered one-hot grant together with its 3-bit index. A grant is held for a burst while the owner keeps requesting, and is pre-empted after `MAX_HOLD` cycles when another requester is waiting. It sits between the requester bank and the shared resource, and its one-hot grant is the 3-to-8 decode of `gnt_idx`.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles before forced hand-off while others wait; legal range 1..15.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous active-low reset.
- `en`  input  1: arbiter enable; when 0, no grants are issued.
- `req`  input  8: per-requester request; bit i corresponds to requester i; level-sensitive.
- `gnt`  output  8: registered one-hot grant; all zero when no grant.
- `gnt_idx`  output  3: index of the granted requester; valid only when `gnt_vld`=1.
- `gnt_vld`  output  1: a grant is active; equals OR of `gnt`.

## Operation
- Internal state:
  - FSM: IDLE or GRANT.
  - `ptr[2:0]`: search start point.
  - `cnt`: hold counter, 4 bits, saturating at `MAX_HOLD`.
- Search function: first i with req[i]=1, scanning circularly `ptr`, `ptr`+1, ... `ptr`+7 (mod 8).
- `gnt` is always `8'd1 << gnt_idx` when `gnt_vld`=1; otherwise `8'd0`.
- IDLE:
  - If `en`=1 and `req`!=0: load `gnt_idx` with the search result, set `gnt_vld`=1, set `cnt`=1, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, with owner o = `gnt_idx`. Evaluate in priority order:
  1. `en`=0: clear the grant, go to IDLE, set `ptr`=o+1.
  2. req[o]=0 (release): set `ptr`=o+1. If any other request is pending, grant the search result from o+1 directly (no idle cycle) and set `cnt`=1. Otherwise clear the grant and go to IDLE.
  3. req[o]=1, `cnt`==`MAX_HOLD`, and another request is pending (pre-emption): grant the first pending requester circularly after o, set `cnt`=1, set `ptr`=o+1.
  4. Else hold the grant; `cnt` increments, saturating at `MAX_HOLD`.
- Release and hold expiry in the same cycle are treated as a release (rule 2).
- `ptr` wraps: o=7 gives `ptr`=0.
- `MAX_HOLD`=1 gives a strict one-cycle rotation among contending requesters.
- A sole requester is never pre-empted. It is held indefinitely with `cnt` saturated.
- Requests arriving mid-burst do not disturb the current owner until rule 2 or rule 3 fires.

## Timing
- All outputs are registered.
- Request-to-grant latency is 1 cycle: req sampled at edge N gives `gnt` valid after edge N.
- Release-to-next-grant is 1 cycle, with no bubble between owners. Release-to-IDLE is also 1 cycle.
- `en` falling: grant removed after the next edge.
- Reset values while `rst_n`=0:
  - `gnt`=8'd0, `gnt_idx`=3'd0, `gnt_vld`=0.
  - `ptr`=0, `cnt`=0, FSM=IDLE.
- Reset is asynchronous. Assertion mid-burst clears the grant immediately, without waiting for `clk`.
- After `rst_n` deasserts, the first arbitration happens at the first rising edge where `en`=1.
- `gnt` is never more than one-hot.
- Owner change occurs only at a `clk` edge.

## Test plan
- Reset/idle: `rst_n`=0 mid-grant with `gnt`=8'h04 → outputs drop to 0 immediately, before the next edge. After release with `req`=0 → `gnt`=0, `gnt_vld`=0.
- Single request: `en`=1, `req`=8'h20 for 10 cycles, `MAX_HOLD`=4 → `gnt`=8'h20 and `gnt_idx`=5 one cycle later, held all 10 cycles. Drop req → `gnt`=0 next cycle.
- Rotation: `req`=8'hFF held, `MAX_HOLD`=2 → `gnt_idx` sequence 0,0,1,1,2,2,...,7,7,0, each owner exactly 2 cycles, no gaps.
- Release hand-off: requesters 1 and 6 both asserted from reset → grant 1. Drop req[1] after 2 cycles → `gnt`=8'h40 on the next cycle. Drop req[6] → `gnt`=0 next cycle, and `ptr`=7.
- Wrap and fairness: owner 7 releases while `req`=8'h81 → next grant is index 0, then 7 after 0 releases.
- Enable/simultaneity:
  - `en`=0 during a burst → `gnt`=0 next cycle; re-enabling with the same requests resumes from `ptr`.
  - Owner dropping req on the cycle `cnt`=`MAX_HOLD` → handled as a release (next owner found from o+1).

Source files
------------

// File: rtl/rr_arb8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb8 : eight-way round-robin arbiter, registered one-hot grant + index |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arb8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld
);

  localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic       r_vld, w_vld_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [7:0] w_others;
  logic [3:0] w_srch_ptr;
  logic [3:0] w_srch_nxt;

  // Returns {found, index} of the first set bit scanning circularly from start.
  function automatic logic [3:0] search(input logic [7:0] r, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] j;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      j = start + 3'(k);
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  assign w_others   = req & ~(8'd1 << r_idx);
  assign w_srch_ptr = search(req, r_ptr);
  assign w_srch_nxt = search(w_others, r_idx + 3'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    case (r_state)
      S_IDLE: begin
        if (en && (req != 8'd0)) begin
          w_idx_nxt   = w_srch_ptr[2:0];
          w_vld_nxt   = 1'b1;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!en) begin
          w_ptr_nxt   = r_idx + 3'd1;
          w_vld_nxt   = 1'b0;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (!req[r_idx]) begin
          // Release wins over hold expiry; hand off without an idle bubble.
          w_ptr_nxt = r_idx + 3'd1;
          if (w_srch_nxt[3]) begin
            w_idx_nxt = w_srch_nxt[2:0];
            w_cnt_nxt = 4'd1;
          end else begin
            w_vld_nxt   = 1'b0;
            w_idx_nxt   = 3'd0;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_IDLE;
          end
        end else if ((r_cnt == C_MAX_HOLD) && w_srch_nxt[3]) begin
          w_ptr_nxt = r_idx + 3'd1;
          w_idx_nxt = w_srch_nxt[2:0];
          w_cnt_nxt = 4'd1;
        end else if (r_cnt != C_MAX_HOLD) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_gnt_nxt = w_vld_nxt ? (8'd1 << w_idx_nxt) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_cnt   <= 4'd0;
      r_idx   <= 3'd0;
      r_vld   <= 1'b0;
      r_gnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_arb8 : scoreboard bench for rr_arb8 (MAX_HOLD = 2)                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

  int errors;
  int checks;

  typedef struct {
    bit         vld;
    logic [2:0] idx;
    string      name;
  } exp_t;

  exp_t sb[$];

  rr_arb8 #(.MAX_HOLD(2)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the grant expected after the next edge.
  task automatic cyc(input logic e, input logic [7:0] r, input int exp_i, input string nm);
    exp_t it;
    @(negedge clk);
    en      = e;
    req     = r;
    it.vld  = (exp_i >= 0);
    it.idx  = 3'(exp_i);
    it.name = nm;
    sb.push_back(it);
  endtask

  // Monitor: pops after every active edge; checks outputs on any reset assertion.
  initial begin
    exp_t       it;
    logic [7:0] eg;
    errors = 0;
    checks = 0;
    #2;
    checks++;
    if (gnt !== 8'd0 || gnt_idx !== 3'd0 || gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: gnt=%h idx=%0d vld=%b, want gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_vld);
    end
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        checks++;
        if (gnt !== 8'd0 || gnt_idx !== 3'd0 || gnt_vld !== 1'b0) begin
          errors++;
          $display("FAIL reset_async: gnt=%h idx=%0d vld=%b, want gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_vld);
        end
      end else if (sb.size() > 0) begin
        it = sb.pop_front();
        eg = it.vld ? (8'd1 << it.idx) : 8'd0;
        checks++;
        if (gnt !== eg || gnt_vld !== it.vld || (it.vld && gnt_idx !== it.idx)) begin
          errors++;
          $display("FAIL %s: gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                   it.name, gnt, gnt_idx, gnt_vld, eg, it.idx, it.vld);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full contention: two cycles per owner, ascending, wrapping to 0.
    for (int k = 0; k < 17; k++) cyc(1'b1, 8'hFF, (k / 2) % 8, "rotation");
    cyc(1'b1, 8'h00, -1, "rot_release");

    // Sole requester held past MAX_HOLD; ptr is 1 here.
    for (int k = 0; k < 10; k++) cyc(1'b1, 8'h20, 5, "single_hold");
    cyc(1'b1, 8'h00, -1, "single_drop");

    // From ptr=6 the scan reaches 2; then reset asynchronously mid-grant.
    cyc(1'b1, 8'h04, 2, "pre_reset_grant");
    cyc(1'b1, 8'h04, 2, "pre_reset_hold");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Release hand-off; drop of req[1] coincides with cnt == MAX_HOLD.
    cyc(1'b1, 8'h42, 1, "handoff_first");
    cyc(1'b1, 8'h42, 1, "handoff_hold");
    cyc(1'b1, 8'h40, 6, "handoff_release");
    cyc(1'b1, 8'h40, 6, "handoff_next_hold");
    cyc(1'b1, 8'h00, -1, "handoff_idle");

    // ptr is now 7: 7 wins over 0, then wraps to 0, then back to 7.
    cyc(1'b1, 8'h81, 7, "wrap_ptr7");
    cyc(1'b1, 8'h01, 0, "wrap_to_0");
    cyc(1'b1, 8'h80, 7, "wrap_back_7");
    cyc(1'b1, 8'h00, -1, "wrap_idle");

    // Enable drop mid-burst, resume from ptr, then pre-emption between 2 and 3.
    cyc(1'b1, 8'h0C, 2, "en_grant");
    cyc(1'b0, 8'h0C, -1, "en_off");
    cyc(1'b0, 8'h0C, -1, "en_off_idle");
    cyc(1'b1, 8'h0C, 3, "en_resume_ptr");
    cyc(1'b1, 8'h0C, 3, "en_hold");
    cyc(1'b1, 8'h0C, 2, "preempt_to_2");
    cyc(1'b1, 8'h0C, 2, "preempt_hold");
    cyc(1'b1, 8'h0C, 3, "preempt_to_3");
    cyc(1'b1, 8'h08, 3, "late_drop_other");
    cyc(1'b1, 8'h00, -1, "final_idle");

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
